wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, master/slave address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; select width DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles with stb high and no ack before abort (timeout builds only).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_m_cyc, input, [1:0], per-master bus cycle request.
REQ-007 SHALL have port i_m_stb, input, [1:0], per-master strobe.
REQ-008 SHALL have port i_m_we, input, [1:0], per-master write enable.
REQ-009 SHALL have port i_m_adr, input, [1:0][ADDR_WIDTH-1:0], per-master address.
REQ-010 SHALL have port i_m_dat, input, [1:0][DATA_WIDTH-1:0], per-master write data.
REQ-011 SHALL have port i_m_sel, input, [1:0][DATA_WIDTH/8-1:0], per-master byte select.
REQ-012 SHALL have port o_m_dat, output, DATA_WIDTH, read data broadcast to both masters.
REQ-013 SHALL have port o_m_ack, output, [1:0], per-master acknowledge.
REQ-014 SHALL have port o_m_err, output, [1:0], per-master bus-timeout error.
REQ-015 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we (output, 1 each), o_wb_adr (output, ADDR_WIDTH), o_wb_dat (output, DATA_WIDTH), o_wb_sel (output, DATA_WIDTH/8), driving the shared slave bus (address decoder input).
REQ-016 SHALL have ports i_wb_dat (input, DATA_WIDTH) and i_wb_ack (input, 1) from the shared slave bus.
REQ-017 SHALL have port o_grant, output, [1:0], one-hot current owner, 2'b00 when idle.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, ERR (ERR only with timeout built in).
REQ-019 IDLE: if any i_m_cyc is high, SHALL register the winner into o_grant and enter BUSY next edge; arbitration latency exactly 1 cycle.
REQ-020 On simultaneous requests, SHALL grant the master not granted last (round-robin); after reset, master 0 wins.
REQ-021 BUSY: o_wb_cyc/stb/we/adr/dat/sel SHALL combinationally follow the owner's inputs; with no owner all slave outputs SHALL be 0.
REQ-022 o_m_ack SHALL be i_wb_ack routed to the owner bit only; non-owner ack and err SHALL stay 0.
REQ-023 Owner SHALL keep the grant across any number of stb/ack beats while its i_m_cyc stays high.
REQ-024 Owner dropping i_m_cyc SHALL return the FSM to IDLE at the next edge with o_grant 0 for one cycle, then re-arbitrate; last-owner register updated on release.
REQ-025 Non-owner requests SHALL wait without any response; a request withdrawn while waiting SHALL be ignored.
REQ-026 i_wb_ack while idle SHALL be discarded.

Reset
REQ-027 i_reset high SHALL asynchronously force IDLE, o_grant 0, last-owner = master 1 (so master 0 wins next), timeout counter 0, all o_wb_* 0, o_m_ack 0, o_m_err 0.
REQ-028 Reset mid-transfer SHALL abort the cycle with no ack or err issued; arbitration resumes the first edge after release.

Configuration
REQ-029 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL count BUSY cycles with o_wb_stb high and i_wb_ack low, clear on ack or release, and on reaching TIMEOUT_CYCLES pulse the owner's o_m_err for one cycle and enter ERR.
REQ-030 In ERR, o_wb_cyc/stb SHALL be 0 and the FSM SHALL return to IDLE when the owner drops i_m_cyc.
REQ-031 Without WB_ARB_TIMEOUT_EN, no counter or ERR state SHALL exist, o_m_err SHALL be tied 0, and a stalled slave holds the grant indefinitely.

Verification
REQ-032 Master 0 alone, read adr 0x1000_0004, slave acks 2 cycles later with 0x55 -> o_grant 01 one cycle after cyc, o_m_ack 01, o_m_dat 0x55.
REQ-033 Both masters request in the same cycle after reset -> master 0 granted first; on its release, one idle cycle then master 1 granted.
REQ-034 Master 1 holds cyc for 4 beats while master 0 requests -> o_grant stays 10 for all 4 acks; master 0 never acked until granted.
REQ-035 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> owner o_m_err pulses after 8 stb cycles, o_wb_cyc low until owner releases.
REQ-036 i_reset asserted mid-beat with stb high -> all outputs 0 immediately; after release master 0 wins a simultaneous request.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter -- two-master Wishbone classic arbiter onto one shared slave bus.
//
// Build option: define WB_ARB_TIMEOUT_EN to add a stall-timeout watchdog
// (counter plus ERR state). Without it the arbiter has IDLE/BUSY only and
// o_m_err is tied low.
//
// Handshake: a beat is offered while o_wb_cyc & o_wb_stb are high and it
// completes in the cycle i_wb_ack is high; the ack is routed only to the
// current owner, and a stalled slave simply leaves the beat pending.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_m_cyc/stb/we        per-master cycle, strobe, write enable [1:0]
//   i_m_adr/dat/sel       per-master address, write data, byte select
//   o_m_dat               slave read data broadcast to both masters
//   o_m_ack, o_m_err      per-master acknowledge and timeout error
//   o_wb_cyc..o_wb_sel    shared slave bus, driven by the owner only
//   i_wb_dat, i_wb_ack    shared slave bus response
//   o_grant               one-hot owner, 2'b00 when idle
//   o_state               FSM state for observation (0 IDLE, 1 BUSY, 2 ERR)
module wb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [1:0]                     i_m_cyc,
    input  logic [1:0]                     i_m_stb,
    input  logic [1:0]                     i_m_we,
    input  logic [1:0][ADDR_WIDTH-1:0]     i_m_adr,
    input  logic [1:0][DATA_WIDTH-1:0]     i_m_dat,
    input  logic [1:0][DATA_WIDTH/8-1:0]   i_m_sel,
    output logic [DATA_WIDTH-1:0]          o_m_dat,
    output logic [1:0]                     o_m_ack,
    output logic [1:0]                     o_m_err,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic                           o_wb_we,
    output logic [ADDR_WIDTH-1:0]          o_wb_adr,
    output logic [DATA_WIDTH-1:0]          o_wb_dat,
    output logic [DATA_WIDTH/8-1:0]        o_wb_sel,
    input  logic [DATA_WIDTH-1:0]          i_wb_dat,
    input  logic                           i_wb_ack,
    output logic [1:0]                     o_grant,
    output logic [1:0]                     o_state
);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;   // index of the master that owned the bus last
    logic       owner;            // index of the current owner (valid when granted)
    logic       winner;

    assign owner = grant_q[1];

    // Round-robin: with both requesting, the master that did not own last wins.
    assign winner = (&i_m_cyc) ? ~last_q : i_m_cyc[1];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;      // master 0 wins the first contest after reset
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|i_m_cyc) begin
                    state_d = BUSY;
                    grant_d = winner ? 2'b10 : 2'b01;
                end
            end
            BUSY: begin
                if (!i_m_cyc[owner]) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = owner;
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (i_wb_ack) begin
                    cnt_d   = '0;
                end else if (i_m_stb[owner]) begin
                    // This is a stalled strobe cycle; the last allowed one aborts.
                    if (cnt_q == CNT_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ERR: begin
                if (!i_m_cyc[owner]) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = owner;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_wb_we  = 1'b0;
        o_wb_adr = '0;
        o_wb_dat = '0;
        o_wb_sel = '0;
        o_m_ack  = 2'b00;
        o_m_err  = 2'b00;
        if (state_q == BUSY) begin
            o_wb_cyc = i_m_cyc[owner];
            o_wb_stb = i_m_stb[owner];
            o_wb_we  = i_m_we[owner];
            o_wb_adr = i_m_adr[owner];
            o_wb_dat = i_m_dat[owner];
            o_wb_sel = i_m_sel[owner];
            o_m_ack  = i_wb_ack ? grant_q : 2'b00;
        end
`ifdef WB_ARB_TIMEOUT_EN
        // err_q is high only in the first ERR cycle, so this is a single pulse.
        if (err_q) begin
            o_m_err = grant_q;
        end
`endif
    end

    assign o_m_dat = i_wb_dat;
    assign o_grant = grant_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic [1:0]         i_m_cyc, i_m_stb, i_m_we;
    logic [1:0][AW-1:0] i_m_adr;
    logic [1:0][DW-1:0] i_m_dat;
    logic [1:0][SW-1:0] i_m_sel;
    logic [DW-1:0]      o_m_dat;
    logic [1:0]         o_m_ack, o_m_err;
    logic               o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]      o_wb_adr;
    logic [DW-1:0]      o_wb_dat;
    logic [SW-1:0]      o_wb_sel;
    logic [DW-1:0]      i_wb_dat;
    logic               i_wb_ack;
    logic [1:0]         o_grant, o_state;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
        .i_m_adr(i_m_adr), .i_m_dat(i_m_dat), .i_m_sel(i_m_sel),
        .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .o_grant(o_grant), .o_state(o_state)
    );

    // ------------------------------------------------------------ clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_m_cyc  = 2'b00;
        i_m_stb  = 2'b00;
        i_m_we   = 2'b00;
        i_m_adr  = '0;
        i_m_dat  = '0;
        i_m_sel  = '0;
        i_wb_dat = '0;
        i_wb_ack = 1'b0;
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // ------------------------------------------------------------ reference model
    // Owner is a master index (-1 = nobody); the bus belongs to the owner until it
    // drops cyc, then one empty cycle, then the next contest.
    int mo_owner, mo_last, mo_stall;
    bit mo_in_err, mo_err_pulse;
    logic [1:0]                e_grant, e_ack, e_err;
    logic [3+AW+DW+SW-1:0]     e_bus;

    task automatic model_reset();
        mo_owner = -1;
        mo_last = 1;
        mo_stall = 0;
        mo_in_err = 0;
        mo_err_pulse = 0;
    endtask

    task automatic model_expect();
        bit serving;
        serving = (mo_owner >= 0) && !mo_in_err;
        e_grant = (mo_owner < 0) ? 2'b00 : 2'(1 << mo_owner);
        e_ack   = (serving && i_wb_ack) ? 2'(1 << mo_owner) : 2'b00;
        e_err   = mo_err_pulse ? 2'(1 << mo_owner) : 2'b00;
        if (serving)
            e_bus = {i_m_cyc[mo_owner], i_m_stb[mo_owner], i_m_we[mo_owner],
                     i_m_adr[mo_owner], i_m_dat[mo_owner], i_m_sel[mo_owner]};
        else
            e_bus = '0;
    endtask

    task automatic model_edge();
        bit pulse;
        pulse = 0;
        if (mo_owner < 0) begin
            if (i_m_cyc == 2'b11) mo_owner = 1 - mo_last;
            else if (i_m_cyc[0]) mo_owner = 0;
            else if (i_m_cyc[1]) mo_owner = 1;
        end else if (!i_m_cyc[mo_owner]) begin
            mo_last = mo_owner;
            mo_owner = -1;
            mo_in_err = 0;
            mo_stall = 0;
        end else if (!mo_in_err) begin
`ifdef WB_ARB_TIMEOUT_EN
            if (i_wb_ack) mo_stall = 0;
            else if (i_m_stb[mo_owner]) begin
                mo_stall++;
                if (mo_stall == TO) begin
                    mo_in_err = 1;
                    pulse = 1;
                    mo_stall = 0;
                end
            end
`endif
        end
        mo_err_pulse = pulse;
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        i_reset = 1'b1;
        drive_idle();
        i_m_cyc = 2'b11;
        i_m_stb = 2'b11;
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_grant: got %b exp 00", o_grant);
        end
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel} !== '0) begin
            failures++;
            $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h exp all zero", o_wb_cyc, o_wb_stb, o_wb_adr);
        end
        checks++;
        if ({o_m_ack, o_m_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack_err: got ack=%b err=%b exp 00/00", o_m_ack, o_m_err);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        apply_reset();
        i_m_cyc[0] = 1'b1;
        i_m_stb[0] = 1'b1;
        i_m_adr[0] = 32'h1000_0004;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL read_latency: got grant %b exp 00", o_grant);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01 || o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h1000_0004) begin
            failures++;
            $display("FAIL read_grant: got grant=%b cyc=%b adr=%h exp 01/1/10000004", o_grant, o_wb_cyc, o_wb_adr);
        end
        tick();
        i_wb_ack = 1'b1;
        i_wb_dat = 32'h55;
        @(negedge i_clk);
        checks++;
        if (o_m_ack !== 2'b01 || o_m_dat !== 32'h55) begin
            failures++;
            $display("FAIL read_ack: got ack=%b dat=%h exp 01/55", o_m_ack, o_m_dat);
        end
        tick();
        i_wb_ack = 1'b0;
        i_m_cyc = 2'b00;
        i_m_stb = 2'b00;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL read_release: got grant %b exp 00", o_grant);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        i_m_cyc = 2'b11;
        i_m_stb = 2'b11;
        tick();
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01 || o_m_ack !== 2'b01) begin
            failures++;
            $display("FAIL rr_first: got grant=%b ack=%b exp 01/01", o_grant, o_m_ack);
        end
        tick();
        i_wb_ack = 1'b0;
        i_m_cyc = 2'b10;
        i_m_stb = 2'b10;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL rr_gap: got grant %b exp 00", o_grant);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b10) begin
            failures++;
            $display("FAIL rr_second: got grant %b exp 10", o_grant);
        end
        i_m_cyc = 2'b00;
        i_m_stb = 2'b00;
        tick();
        i_m_cyc = 2'b11;
        i_m_stb = 2'b11;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01) begin
            failures++;
            $display("FAIL rr_alternate: got grant %b exp 01", o_grant);
        end
    endtask

    task automatic test_hold_beats();
        int acks_seen;
        apply_reset();
        i_m_cyc = 2'b10;
        i_m_stb = 2'b10;
        tick();
        i_m_cyc = 2'b11;
        i_m_stb = 2'b11;
        acks_seen = 0;
        for (int b = 0; b < 4; b++) begin
            i_wb_ack = 1'b1;
            @(negedge i_clk);
            if (o_grant == 2'b10 && o_m_ack == 2'b10) acks_seen++;
            tick();
            i_wb_ack = 1'b0;
            @(negedge i_clk);
            if (o_grant !== 2'b10 || o_m_ack !== 2'b00) acks_seen = -100;
            tick();
        end
        checks++;
        if (acks_seen !== 4) begin
            failures++;
            $display("FAIL hold_beats: got %0d clean owner beats exp 4", acks_seen);
        end
        i_m_cyc = 2'b01;
        i_m_stb = 2'b01;
        tick();
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01) begin
            failures++;
            $display("FAIL hold_handover: got grant %b exp 01", o_grant);
        end
    endtask

    task automatic test_idle_ack_withdraw();
        apply_reset();
        i_wb_ack = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_m_ack !== 2'b00 || o_wb_cyc !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack: got ack=%b cyc=%b exp 00/0", o_m_ack, o_wb_cyc);
        end
        tick();
        i_wb_ack = 1'b0;
        i_m_cyc = 2'b01;
        tick();
        i_m_cyc = 2'b11;
        tick();
        i_m_cyc = 2'b01;
        tick();
        i_m_cyc = 2'b00;
        tick();
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL withdraw: got grant %b exp 00", o_grant);
        end
    endtask

    task automatic test_reset_mid_beat();
        apply_reset();
        i_m_cyc = 2'b01;
        tick();
        i_m_cyc = 2'b00;
        tick();
        i_m_cyc = 2'b10;
        i_m_stb = 2'b10;
        i_m_adr[1] = 32'hdead_beef;
        tick();
        tick();
        i_wb_ack = 1'b1;
        i_m_cyc = 2'b11;
        i_m_stb = 2'b11;
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if ({o_grant, o_m_ack, o_m_err, o_wb_cyc, o_wb_stb} !== 8'h00 || o_wb_adr !== '0) begin
            failures++;
            $display("FAIL reset_mid: got grant=%b ack=%b err=%b cyc=%b stb=%b adr=%h exp all zero",
                     o_grant, o_m_ack, o_m_err, o_wb_cyc, o_wb_stb, o_wb_adr);
        end
        tick();
        i_reset = 1'b0;
        i_wb_ack = 1'b0;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_rearb: got grant %b exp 01", o_grant);
        end
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        i_m_cyc = 2'b01;
        i_m_stb = 2'b01;
        tick();
        bad = 0;
        for (int k = 0; k < TO; k++) begin
            @(negedge i_clk);
            if (o_m_err !== 2'b00 || o_wb_cyc !== 1'b1 || o_grant !== 2'b01) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL timeout_stall: got %0d bad stall cycles exp 0", bad);
        end
`ifdef WB_ARB_TIMEOUT_EN
        @(negedge i_clk);
        checks++;
        if (o_m_err !== 2'b01 || o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err: got err=%b cyc=%b stb=%b exp 01/0/0", o_m_err, o_wb_cyc, o_wb_stb);
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_m_err !== 2'b00 || o_wb_cyc !== 1'b0 || o_grant !== 2'b01) begin
            failures++;
            $display("FAIL timeout_hold: got err=%b cyc=%b grant=%b exp 00/0/01", o_m_err, o_wb_cyc, o_grant);
        end
        i_m_cyc = 2'b00;
        i_m_stb = 2'b00;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_grant !== 2'b00) begin
            failures++;
            $display("FAIL timeout_release: got grant %b exp 00", o_grant);
        end
`else
        repeat (20) tick();
        @(negedge i_clk);
        checks++;
        if (o_m_err !== 2'b00 || o_wb_cyc !== 1'b1 || o_grant !== 2'b01) begin
            failures++;
            $display("FAIL no_timeout: got err=%b cyc=%b grant=%b exp 00/1/01", o_m_err, o_wb_cyc, o_grant);
        end
`endif
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        int stall_left;
        apply_reset();
        model_reset();
        stall_left = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!i_m_cyc[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        i_m_cyc[m] = 1'b1;
                        i_m_we[m]  = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    i_m_cyc[m] = 1'b0;
                end
                i_m_stb[m] = i_m_cyc[m] & 1'($urandom_range(0, 3) != 0);
                i_m_adr[m] = $urandom();
                i_m_dat[m] = $urandom();
                i_m_sel[m] = SW'($urandom_range(0, (1 << SW) - 1));
            end
            if (stall_left == 0 && $urandom_range(0, 39) == 0) stall_left = 12;
            if (stall_left > 0) begin
                stall_left--;
                i_wb_ack = 1'b0;
            end else begin
                i_wb_ack = 1'($urandom_range(0, 1));
            end
            i_wb_dat = $urandom();
            @(negedge i_clk);
            model_expect();
            checks++;
            if (o_grant !== e_grant) begin
                failures++;
                $display("FAIL rand_grant c=%0d: got %b exp %b", c, o_grant, e_grant);
            end
            checks++;
            if (o_m_ack !== e_ack) begin
                failures++;
                $display("FAIL rand_ack c=%0d: got %b exp %b", c, o_m_ack, e_ack);
            end
            checks++;
            if (o_m_err !== e_err) begin
                failures++;
                $display("FAIL rand_err c=%0d: got %b exp %b", c, o_m_err, e_err);
            end
            checks++;
            if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel} !== e_bus) begin
                failures++;
                $display("FAIL rand_bus c=%0d: got %h exp %h", c,
                         {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel}, e_bus);
            end
            checks++;
            if (o_m_dat !== i_wb_dat) begin
                failures++;
                $display("FAIL rand_rdata c=%0d: got %h exp %h", c, o_m_dat, i_wb_dat);
            end
            model_edge();
            tick();
        end
        drive_idle();
    endtask

    // ------------------------------------------------------------ sequence + report
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold_beats();
        test_idle_ack_withdraw();
        test_reset_mid_beat();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
